// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between two requesters
//   (PORT_A, PORT_B) with round-robin arbitration, at most one memory
//   command per cycle. Read data is routed back to the issuing port and
//   per-port write acknowledges are generated from fixed memory latencies.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   x_req/x_op/x_addr/x_wdata  requester command (x = a, b); op 01 WRITE,
//                           10 READ, 00/11 ignored; held until x_gnt
//   x_gnt                   command accepted this cycle (combinational)
//   x_wack                  write complete, 1-cycle pulse
//   x_rvalid/x_rdata        read data return, rdata holds when rvalid=0
//   mem_en/we/addr/wdata    registered command to the memory macro
//   mem_rdata               memory read data, valid R_LTY cycles after mem_en
module mem_port_arbiter #(
  parameter int unsigned D_W   = 32,
  parameter int unsigned A_W   = 10,
  parameter int unsigned R_LTY = 1,
  parameter int unsigned W_LTY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           a_req,
  input  logic [1:0]     a_op,
  input  logic [A_W-1:0] a_addr,
  input  logic [D_W-1:0] a_wdata,
  output logic           a_gnt,
  output logic           a_wack,
  output logic           a_rvalid,
  output logic [D_W-1:0] a_rdata,
  input  logic           b_req,
  input  logic [1:0]     b_op,
  input  logic [A_W-1:0] b_addr,
  input  logic [D_W-1:0] b_wdata,
  output logic           b_gnt,
  output logic           b_wack,
  output logic           b_rvalid,
  output logic [D_W-1:0] b_rdata,
  output logic           mem_en,
  output logic           mem_we,
  output logic [A_W-1:0] mem_addr,
  output logic [D_W-1:0] mem_wdata,
  input  logic [D_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10
  } op_e;

  logic           w_a_vld;
  logic           w_b_vld;
  logic           w_a_gnt;
  logic           w_b_gnt;
  logic           w_any_gnt;

  logic           r_last_b;   // 1: PORT_B was granted most recently
  logic           r_mem_en;
  logic           r_mem_we;
  logic [A_W-1:0] r_mem_addr;
  logic [D_W-1:0] r_mem_wdata;
  logic           r_iss_b;    // port id of the command currently on mem_*

  // Per-port in-flight tags; bit 0 is the youngest stage
  logic [R_LTY-1:0] r_rd_a;
  logic [R_LTY-1:0] r_rd_b;
  logic [W_LTY-1:0] r_wr_a;
  logic [W_LTY-1:0] r_wr_b;
  logic [R_LTY:0]   w_rd_a_nxt;
  logic [R_LTY:0]   w_rd_b_nxt;
  logic [W_LTY:0]   w_wr_a_nxt;
  logic [W_LTY:0]   w_wr_b_nxt;

  logic           r_a_rvalid;
  logic           r_b_rvalid;
  logic [D_W-1:0] r_a_rdata;
  logic [D_W-1:0] r_b_rdata;

  always_comb begin
    w_a_vld   = a_req && (a_op == OP_WR || a_op == OP_RD);
    w_b_vld   = b_req && (b_op == OP_WR || b_op == OP_RD);
    // Grants are gated by rst_n so they drop immediately during reset
    w_a_gnt   = rst_n && w_a_vld && (!w_b_vld || r_last_b);
    w_b_gnt   = rst_n && w_b_vld && (!w_a_vld || !r_last_b);
    w_any_gnt = w_a_gnt || w_b_gnt;
  end

  // Concatenation form keeps the shift legal for a depth of 1
  always_comb begin
    w_rd_a_nxt = {r_rd_a, r_mem_en && !r_mem_we && !r_iss_b};
    w_rd_b_nxt = {r_rd_b, r_mem_en && !r_mem_we &&  r_iss_b};
    w_wr_a_nxt = {r_wr_a, r_mem_en &&  r_mem_we && !r_iss_b};
    w_wr_b_nxt = {r_wr_b, r_mem_en &&  r_mem_we &&  r_iss_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b    <= 1'b1;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_iss_b     <= 1'b0;
    end else begin
      r_mem_en <= w_any_gnt;
      if (w_any_gnt) begin
        r_last_b    <= w_b_gnt;
        r_iss_b     <= w_b_gnt;
        r_mem_we    <= w_b_gnt ? (b_op == OP_WR) : (a_op == OP_WR);
        r_mem_addr  <= w_b_gnt ? b_addr  : a_addr;
        r_mem_wdata <= w_b_gnt ? b_wdata : a_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_a     <= '0;
      r_rd_b     <= '0;
      r_wr_a     <= '0;
      r_wr_b     <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_rd_a     <= w_rd_a_nxt[R_LTY-1:0];
      r_rd_b     <= w_rd_b_nxt[R_LTY-1:0];
      r_wr_a     <= w_wr_a_nxt[W_LTY-1:0];
      r_wr_b     <= w_wr_b_nxt[W_LTY-1:0];
      // Oldest read tag lines up with the cycle mem_rdata is valid
      r_a_rvalid <= r_rd_a[R_LTY-1];
      r_b_rvalid <= r_rd_b[R_LTY-1];
      if (r_rd_a[R_LTY-1]) r_a_rdata <= mem_rdata;
      if (r_rd_b[R_LTY-1]) r_b_rdata <= mem_rdata;
    end
  end

  assign a_gnt     = w_a_gnt;
  assign b_gnt     = w_b_gnt;
  assign a_wack    = r_wr_a[W_LTY-1];
  assign b_wack    = r_wr_b[W_LTY-1];
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two instances share the same requester stimulus: instance 0 with
//   R_LTY=1/W_LTY=1, instance 1 with R_LTY=3/W_LTY=2. Each has its own
//   memory macro model. Expected behaviour comes from a transaction-level
//   model: grant decision from the round-robin rule, a shadow memory
//   updated in grant order, and per-cycle schedules of acks and read returns.
module tb_mem_port_arbiter;

  localparam int unsigned R0 = 1;
  localparam int unsigned W0 = 1;
  localparam int unsigned R1 = 3;
  localparam int unsigned W1 = 2;
  localparam int NC = 2048;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  logic        clk;
  logic        rst_n;
  logic        a_req, b_req;
  logic [1:0]  a_op, b_op;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic        gnt_w  [2][2];
  logic        wack_w [2][2];
  logic        rv_w   [2][2];
  logic [31:0] rd_w   [2][2];
  logic        men    [2];
  logic        mwe    [2];
  logic [9:0]  maddr  [2];
  logic [31:0] mwd    [2];
  logic [31:0] mrd    [2];

  mem_port_arbiter #(.D_W(32), .A_W(10), .R_LTY(R0), .W_LTY(W0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(gnt_w[0][0]), .a_wack(wack_w[0][0]), .a_rvalid(rv_w[0][0]), .a_rdata(rd_w[0][0]),
    .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(gnt_w[0][1]), .b_wack(wack_w[0][1]), .b_rvalid(rv_w[0][1]), .b_rdata(rd_w[0][1]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mrd[0])
  );

  mem_port_arbiter #(.D_W(32), .A_W(10), .R_LTY(R1), .W_LTY(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(gnt_w[1][0]), .a_wack(wack_w[1][0]), .a_rvalid(rv_w[1][0]), .a_rdata(rd_w[1][0]),
    .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(gnt_w[1][1]), .b_wack(wack_w[1][1]), .b_rvalid(rv_w[1][1]), .b_rdata(rd_w[1][1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mrd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro models: write and read at the edge ending the mem_en
  // cycle, read data then delayed to appear R_LTY cycles after mem_en.
  logic        mem_clr;
  logic [31:0] marr [2][1024];
  logic [31:0] rp   [2][3];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_clr) begin
        for (int i = 0; i < 1024; i++) marr[k][i] <= '0;
      end else if (men[k] && mwe[k]) begin
        marr[k][maddr[k]] <= mwd[k];
      end
      rp[k][0] <= marr[k][maddr[k]];
      rp[k][1] <= rp[k][0];
      rp[k][2] <= rp[k][1];
    end
  end
  assign mrd[0] = rp[0][R0-1];
  assign mrd[1] = rp[1][R1-1];

  // Reference model state
  int          n_vec;
  int          n_err;
  int          cyc;
  bit          last_b;
  bit          exp_en;
  bit          exp_we;
  logic [9:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic [31:0] hold   [2][2];
  logic [31:0] shadow [1024];
  bit          sch_wa [2][2][NC];
  bit          sch_rv [2][2][NC];
  logic [31:0] sch_rd [2][2][NC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    last_b    = 1'b1;
    exp_en    = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        hold[k][p] = '0;
        for (int i = 0; i < NC; i++) begin
          sch_wa[k][p][i] = 1'b0;
          sch_rv[k][p][i] = 1'b0;
          sch_rd[k][p][i] = '0;
        end
      end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_mem_en[%0d]", tag, k),    32'(men[k]),   32'd0);
      chk($sformatf("%s_mem_we[%0d]", tag, k),    32'(mwe[k]),   32'd0);
      chk($sformatf("%s_mem_addr[%0d]", tag, k),  32'(maddr[k]), 32'd0);
      chk($sformatf("%s_mem_wdata[%0d]", tag, k), mwd[k],        32'd0);
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("%s_gnt[%0d][%0d]", tag, k, p),    32'(gnt_w[k][p]),  32'd0);
        chk($sformatf("%s_wack[%0d][%0d]", tag, k, p),   32'(wack_w[k][p]), 32'd0);
        chk($sformatf("%s_rvalid[%0d][%0d]", tag, k, p), 32'(rv_w[k][p]),   32'd0);
        chk($sformatf("%s_rdata[%0d][%0d]", tag, k, p),  rd_w[k][p],        32'd0);
      end
    end
  endtask

  // Called mid-cycle; pulls reset low, checks outputs clear at once,
  // holds reset across one edge, then releases it mid-cycle.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 check_zero("rst");
    model_reset();
    @(posedge clk);
    #1 cyc++;
    check_zero("rst_hold");
    rst_n = 1'b1;
  endtask

  // One cycle: check outputs at the negedge against the model, then let
  // the model account for this cycle's grant and drop granted requests.
  task automatic tick();
    bit va, vb, ga, gb, is_wr;
    int p, idx;
    logic [9:0] ad;
    @(negedge clk);
    va = rst_n && a_req && (a_op == OP_WR || a_op == OP_RD);
    vb = rst_n && b_req && (b_op == OP_WR || b_op == OP_RD);
    if (va && vb) begin
      ga = last_b;
      gb = !last_b;
    end else begin
      ga = va;
      gb = vb;
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("a_gnt[%0d]", k),     32'(gnt_w[k][0]), 32'(ga));
      chk($sformatf("b_gnt[%0d]", k),     32'(gnt_w[k][1]), 32'(gb));
      chk($sformatf("mem_en[%0d]", k),    32'(men[k]),      32'(exp_en));
      chk($sformatf("mem_we[%0d]", k),    32'(mwe[k]),      32'(exp_we));
      chk($sformatf("mem_addr[%0d]", k),  32'(maddr[k]),    32'(exp_addr));
      chk($sformatf("mem_wdata[%0d]", k), mwd[k],           exp_wdata);
      for (int q = 0; q < 2; q++) begin
        if (sch_rv[k][q][cyc]) hold[k][q] = sch_rd[k][q][cyc];
        chk($sformatf("wack[%0d][%0d]", k, q),   32'(wack_w[k][q]), 32'(sch_wa[k][q][cyc]));
        chk($sformatf("rvalid[%0d][%0d]", k, q), 32'(rv_w[k][q]),   32'(sch_rv[k][q][cyc]));
        chk($sformatf("rdata[%0d][%0d]", k, q),  rd_w[k][q],        hold[k][q]);
      end
    end
    exp_en = ga || gb;
    if (ga || gb) begin
      p         = gb ? 1 : 0;
      ad        = gb ? b_addr : a_addr;
      is_wr     = gb ? (b_op == OP_WR) : (a_op == OP_WR);
      exp_we    = is_wr;
      exp_addr  = ad;
      exp_wdata = gb ? b_wdata : a_wdata;
      last_b    = gb;
      for (int k = 0; k < 2; k++) begin
        if (is_wr) begin
          idx = cyc + 1 + int'(k == 0 ? W0 : W1);
          if (idx < NC) sch_wa[k][p][idx] = 1'b1;
        end else begin
          idx = cyc + 2 + int'(k == 0 ? R0 : R1);
          if (idx < NC) begin
            sch_rv[k][p][idx] = 1'b1;
            sch_rd[k][p][idx] = shadow[ad];
          end
        end
      end
      if (is_wr) shadow[ad] = exp_wdata;
    end
    @(posedge clk);
    #1 cyc++;
    if (ga) a_req = 1'b0;
    if (gb) b_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_a(input logic [1:0] op, input logic [9:0] ad, input logic [31:0] d);
    a_req = 1'b1; a_op = op; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic [1:0] op, input logic [9:0] ad, input logic [31:0] d);
    b_req = 1'b1; b_op = op; b_addr = ad; b_wdata = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    mem_clr = 1'b1;
    for (int i = 0; i < 1024; i++) shadow[i] = '0;
    model_reset();
    // Valid requests during reset must not be granted
    set_a(OP_RD, 10'h001, 32'h0);
    set_b(OP_WR, 10'h002, 32'h1);
    @(posedge clk);
    #1 check_zero("por");
    mem_clr = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    rst_n = 1'b1;

    // Write then read-back from PORT_A
    set_a(OP_WR, 10'h005, 32'hDEADBEEF);
    tick();
    set_a(OP_RD, 10'h005, 32'h0);
    tick();
    idle(6);

    // Simultaneous reads right after reset: A wins first
    do_reset();
    set_a(OP_RD, 10'h010, 32'h0);
    set_b(OP_RD, 10'h020, 32'h0);
    tick();
    tick();
    idle(6);

    // Continuous requests from both ports for 8 cycles
    for (int i = 0; i < 8; i++) begin
      set_a((i % 3 == 0) ? OP_WR : OP_RD, 10'(i + 8), $urandom);
      set_b((i % 2 == 0) ? OP_WR : OP_RD, 10'(i + 9), $urandom);
      tick();
    end
    a_req = 1'b0;
    b_req = 1'b0;
    idle(6);

    // Write from B, read of the same top address from A next cycle
    set_b(OP_WR, 10'h3FF, 32'h12345678);
    tick();
    set_a(OP_RD, 10'h3FF, 32'h0);
    tick();
    idle(6);

    // Requests with NO_OP and the reserved op are ignored
    for (int i = 0; i < 5; i++) begin
      set_a(OP_NOP, 10'(i), 32'h0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_b(2'b11, 10'(i), 32'h0);
      tick();
    end
    a_req = 1'b0;
    b_req = 1'b0;
    idle(2);

    // Reset in the issue cycle of a read: no read return afterwards
    set_a(OP_RD, 10'h040, 32'h0);
    tick();
    do_reset();
    idle(8);

    // Randomized traffic; invalid requests are re-drawn each cycle,
    // valid ones are held until granted
    for (int n = 0; n < 1500; n++) begin
      if (!(a_req && (a_op == OP_WR || a_op == OP_RD))) begin
        a_req   = ($urandom_range(0, 2) != 0);
        a_op    = 2'($urandom_range(0, 3));
        a_addr  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
        a_wdata = $urandom;
      end
      if (!(b_req && (b_op == OP_WR || b_op == OP_RD))) begin
        b_req   = ($urandom_range(0, 2) != 0);
        b_op    = 2'($urandom_range(0, 3));
        b_addr  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
        b_wdata = $urandom;
      end
      tick();
    end
    a_req = 1'b0;
    b_req = 1'b0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
